// File: rtl/pwm_timebase_if.sv
// Control and status bundle between a PWM timebase and its comparator/controller.
`timescale 1ns/1ps
interface pwm_timebase_if #(
  parameter int CNT_W = 15,
  parameter int PSC_W = 8
);
  logic             en;
  logic             clr;
  logic             mode;
  logic             load;
  logic [CNT_W-1:0] period_in;
  logic [PSC_W-1:0] psc_in;
  logic [CNT_W-1:0] counter;
  logic             tick;
  logic             tc;
  logic             zero;
  logic             dir;
  logic             pending;

  modport master (
    output en, clr, mode, load, period_in, psc_in,
    input  counter, tick, tc, zero, dir, pending
  );

  modport slave (
    input  en, clr, mode, load, period_in, psc_in,
    output counter, tick, tc, zero, dir, pending
  );
endinterface

// File: rtl/pwm_timebase.sv
// Prescaled up / up-down PWM period counter with double-buffered period and prescale.
// All outputs registered (1 clk after the internal tick); no backpressure, en=0 freezes.
`timescale 1ns/1ps
module pwm_timebase #(
  parameter int CNT_W          = 15,
  parameter int PSC_W          = 8,
  parameter int DEFAULT_PERIOD = 15,
  parameter int DEFAULT_PSC    = 0
) (
  input  logic           clk,
  input  logic           rst_a,
  pwm_timebase_if.slave  bus
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] period_shd;
  logic [PSC_W-1:0] psc_cnt;
  logic [PSC_W-1:0] psc_act;
  logic [PSC_W-1:0] psc_shd;
  logic             dir_q;
  logic             dir_nxt;
  logic             tc_nxt;
  logic             zero_nxt;
  logic             tick_q;
  logic             tc_q;
  logic             zero_q;
  logic             pending_q;
  logic             int_tick;
  logic             xfer;

  // >= so a prescale shrunk by an idle-time transfer cannot strand psc_cnt above it
  assign int_tick = bus.en && !bus.clr && (psc_cnt >= psc_act);
  assign xfer     = bus.clr || !bus.en || (int_tick && zero_nxt);

  always_comb begin
    cnt_nxt  = cnt_q;
    dir_nxt  = dir_q;
    tc_nxt   = 1'b0;
    zero_nxt = 1'b0;
    if (!bus.mode) begin
      dir_nxt = 1'b0;
      if (cnt_q >= period_act) begin
        cnt_nxt  = '0;
        tc_nxt   = 1'b1;
        zero_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_q + 1'b1;
      end
    end else if (period_act == '0) begin
      cnt_nxt  = '0;
      dir_nxt  = 1'b0;
      tc_nxt   = 1'b1;
      zero_nxt = 1'b1;
    end else if (!dir_q) begin
      // Also catches a count left above the period by a mode switch or transfer
      if (cnt_q >= period_act - 1'b1) begin
        cnt_nxt = period_act;
        dir_nxt = 1'b1;
        tc_nxt  = 1'b1;
      end else begin
        cnt_nxt = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q <= CNT_W'(1)) begin
        cnt_nxt  = '0;
        dir_nxt  = 1'b0;
        zero_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      cnt_q      <= '0;
      psc_cnt    <= '0;
      dir_q      <= 1'b0;
      tick_q     <= 1'b0;
      tc_q       <= 1'b0;
      zero_q     <= 1'b0;
      pending_q  <= 1'b0;
      period_act <= CNT_W'(DEFAULT_PERIOD);
      period_shd <= CNT_W'(DEFAULT_PERIOD);
      psc_act    <= PSC_W'(DEFAULT_PSC);
      psc_shd    <= PSC_W'(DEFAULT_PSC);
    end else begin
      tick_q <= int_tick;
      tc_q   <= int_tick && tc_nxt;
      zero_q <= int_tick && zero_nxt;

      if (bus.clr) begin
        cnt_q   <= '0;
        psc_cnt <= '0;
        dir_q   <= 1'b0;
      end else if (bus.en) begin
        if (int_tick) begin
          psc_cnt <= '0;
          cnt_q   <= cnt_nxt;
          dir_q   <= dir_nxt;
        end else begin
          psc_cnt <= psc_cnt + 1'b1;
        end
      end

      // Transfer reads the shadow before a coincident load overwrites it
      if (xfer) begin
        period_act <= period_shd;
        psc_act    <= psc_shd;
      end
      if (bus.load) begin
        period_shd <= bus.period_in;
        psc_shd    <= bus.psc_in;
        pending_q  <= 1'b1;
      end else if (xfer) begin
        pending_q  <= 1'b0;
      end
    end
  end

  assign bus.counter = cnt_q;
  assign bus.tick    = tick_q;
  assign bus.tc      = tc_q;
  assign bus.zero    = zero_q;
  assign bus.dir     = dir_q;
  assign bus.pending = pending_q;

endmodule
